ppg_afe_calibrator: RTL



---
 rtl/ppg_afe_calibrator.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ppg_afe_calibrator.sv
// ppg_afe_calibrator
// Calibrates each LED channel of the PPG front end in turn: the DC-compensation
// code is servoed until the windowed ADC mean lands in the target band, then the
// PGA gain is raised until one step before clipping. Afterwards the LEDs are
// time-multiplexed with their stored codes and tagged samples are streamed out.
//
// Stream semantics: adc_valid qualifies adc in the cycle it is high; there is
// no ready, every valid sample is consumed. smp_valid is a one-cycle strobe
// qualifying smp_ch/smp_data with the same valid-only meaning.
module ppg_afe_calibrator #(
  parameter int ADC_W    = 8,
  parameter int N_CH     = 2,
  parameter int DC_W     = 7,
  parameter int GAIN_W   = 4,
  parameter int WIN      = 27,
  parameter int SETTLE   = 2,
  parameter int DC_LO    = 110,
  parameter int DC_HI    = 145,
  parameter int CLIP_LO  = 10,
  parameter int CLIP_HI  = 245,
  parameter int MAX_ITER = 127,
  parameter int DWELL    = 10,
  parameter int DRIVE    = 10,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic              adc_valid,
  input  logic [ADC_W-1:0]  adc,
  output logic [N_CH-1:0]   led_en,
  output logic [3:0]        led_drive,
  output logic [DC_W-1:0]   dc_comp,
  output logic [GAIN_W-1:0] pga_gain,
  output logic              clk_filter,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [CH_W-1:0]   fail_ch,
  output logic              smp_valid,
  output logic [CH_W-1:0]   smp_ch,
  output logic [ADC_W-1:0]  smp_data
);

  localparam int SUM_W = ADC_W + $clog2(WIN);
  localparam int WC_W  = $clog2(WIN);
  localparam int SC_W  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int IT_W  = $clog2(MAX_ITER + 1);
  localparam int SL_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [WC_W-1:0]  WIN_LAST  = WC_W'(WIN - 1);
  localparam logic [SC_W-1:0]  SETTLE_V  = SC_W'(SETTLE);
  localparam logic [IT_W-1:0]  ITER_MAX  = IT_W'(MAX_ITER);
  localparam logic [SL_W-1:0]  SLOT_LAST = SL_W'(DWELL - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);
  // The mean is never divided out: floor(sum/WIN) < LO  <=>  sum < LO*WIN,
  // and floor(sum/WIN) > HI  <=>  sum >= (HI+1)*WIN.
  localparam logic [SUM_W-1:0] LO_SUM    = SUM_W'(DC_LO * WIN);
  localparam logic [SUM_W-1:0] HI_SUM    = SUM_W'((DC_HI + 1) * WIN);
  localparam logic [ADC_W-1:0] CLIP_LO_V = ADC_W'(CLIP_LO);
  localparam logic [ADC_W-1:0] CLIP_HI_V = ADC_W'(CLIP_HI);

  typedef enum logic [2:0] {S_IDLE, S_DC_CAL, S_GAIN_CAL, S_RUN, S_FAIL} state_t;
  state_t state, state_n;

  logic [CH_W-1:0]   ch, slot_ch;
  logic [DC_W-1:0]   dc_code;
  logic [GAIN_W-1:0] gain_code;
  logic [IT_W-1:0]   iter_cnt;
  logic [SC_W-1:0]   settle_cnt;
  logic [WC_W-1:0]   win_cnt;
  logic [SUM_W-1:0]  sum_q, sum_n;
  logic [ADC_W-1:0]  min_q, max_q, min_n, max_n;
  logic [SL_W-1:0]   slot_cnt;
  logic [DC_W-1:0]   dc_store   [N_CH];
  logic [GAIN_W-1:0] gain_store [N_CH];

  logic settled, win_last, dc_low, dc_high, dc_fail, clipped, gain_done, last_ch;
  logic [N_CH-1:0]   led_en_d;
  logic [DC_W-1:0]   dc_d;
  logic [GAIN_W-1:0] gain_d;

  // Window bookkeeping and the decisions taken on a window's last sample.
  always_comb begin
    settled   = (settle_cnt == SETTLE_V);
    win_last  = adc_valid && settled && (win_cnt == WIN_LAST);
    sum_n     = sum_q + SUM_W'(adc);
    min_n     = (adc < min_q) ? adc : min_q;
    max_n     = (adc > max_q) ? adc : max_q;
    dc_low    = (sum_n < LO_SUM);
    dc_high   = (sum_n >= HI_SUM);
    dc_fail   = (dc_low && (dc_code == '0)) || (dc_high && (dc_code == '1)) ||
                ((dc_low || dc_high) && (iter_cnt == ITER_MAX));
    clipped   = (min_n < CLIP_LO_V) || (max_n > CLIP_HI_V);
    gain_done = clipped || (gain_code == '1);
    last_ch   = (ch == CH_LAST);
  end

  // State register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic; start restarts calibration from any state.
  always_comb begin
    state_n = state;
    if (start) begin
      state_n = S_DC_CAL;
    end else begin
      case (state)
        S_DC_CAL: begin
          if (win_last) begin
            if (dc_fail)                state_n = S_FAIL;
            else if (!dc_low && !dc_high) state_n = S_GAIN_CAL;
          end
        end
        S_GAIN_CAL: begin
          if (win_last && gain_done) state_n = last_ch ? S_RUN : S_DC_CAL;
        end
        default: ;
      endcase
    end
  end

  // Calibration datapath: windows, code stepping, per-channel storage, run slots.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ch <= '0; slot_ch <= '0; dc_code <= '0; gain_code <= '0; iter_cnt <= '0;
      settle_cnt <= '0; win_cnt <= '0; sum_q <= '0; min_q <= '1; max_q <= '0;
      slot_cnt <= '0; fail_ch <= '0;
      for (int i = 0; i < N_CH; i++) begin
        dc_store[i]   <= '0;
        gain_store[i] <= '0;
      end
    end else if (start) begin
      // A sample arriving with start is dropped by clearing the window here.
      ch <= '0; dc_code <= '0; gain_code <= '0; iter_cnt <= '0; fail_ch <= '0;
      settle_cnt <= '0; win_cnt <= '0; sum_q <= '0; min_q <= '1; max_q <= '0;
    end else begin
      case (state)
        S_DC_CAL, S_GAIN_CAL: begin
          if (adc_valid) begin
            if (!settled) begin
              settle_cnt <= settle_cnt + SC_W'(1);
            end else if (!win_last) begin
              win_cnt <= win_cnt + WC_W'(1);
              sum_q   <= sum_n;
              min_q   <= min_n;
              max_q   <= max_n;
            end else begin
              settle_cnt <= '0; win_cnt <= '0; sum_q <= '0; min_q <= '1; max_q <= '0;
              if (state == S_DC_CAL) begin
                if (dc_fail) begin
                  fail_ch <= ch;
                end else if (dc_low) begin
                  dc_code  <= dc_code - DC_W'(1);
                  iter_cnt <= iter_cnt + IT_W'(1);
                end else if (dc_high) begin
                  dc_code  <= dc_code + DC_W'(1);
                  iter_cnt <= iter_cnt + IT_W'(1);
                end else begin
                  dc_store[ch] <= dc_code;
                end
              end else if (!gain_done) begin
                gain_code <= gain_code + GAIN_W'(1);
              end else begin
                // Clipping backs off one step; an unclipped max gain is kept.
                gain_store[ch] <= !clipped ? gain_code :
                                  (gain_code == '0) ? '0 : gain_code - GAIN_W'(1);
                if (!last_ch) begin
                  ch <= ch + CH_W'(1); dc_code <= '0; gain_code <= '0; iter_cnt <= '0;
                end else begin
                  slot_ch <= '0; slot_cnt <= '0;
                end
              end
            end
          end
        end
        S_RUN: begin
          if (slot_cnt == SLOT_LAST) begin
            slot_cnt   <= '0;
            slot_ch    <= (slot_ch == CH_LAST) ? '0 : slot_ch + CH_W'(1);
            settle_cnt <= '0;
          end else begin
            slot_cnt <= slot_cnt + SL_W'(1);
            if (adc_valid && !settled) settle_cnt <= settle_cnt + SC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Run-mode sample tagging; a switch-edge sample keeps the outgoing slot's tag.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      smp_valid <= 1'b0; smp_ch <= '0; smp_data <= '0;
    end else begin
      smp_valid <= (state == S_RUN) && adc_valid && settled && !start;
      if ((state == S_RUN) && adc_valid && settled && !start) begin
        smp_ch   <= slot_ch;
        smp_data <= adc;
      end
    end
  end

  // Output decode from the current state.
  always_comb begin
    led_en_d = '0;
    dc_d     = dc_code;
    gain_d   = gain_code;
    case (state)
      S_DC_CAL, S_GAIN_CAL: led_en_d = N_CH'(1) << ch;
      S_RUN: begin
        led_en_d = N_CH'(1) << slot_ch;
        dc_d     = dc_store[slot_ch];
        gain_d   = gain_store[slot_ch];
      end
      default: ;
    endcase
  end

  // Registered outputs and the CLK/2 switched-cap filter clock.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      led_en <= '0; led_drive <= '0; dc_comp <= '0; pga_gain <= '0;
      busy <= 1'b0; done <= 1'b0; fail <= 1'b0; clk_filter <= 1'b0;
    end else begin
      led_en     <= led_en_d;
      led_drive  <= (led_en_d != '0) ? 4'(DRIVE) : 4'd0;
      dc_comp    <= dc_d;
      pga_gain   <= gain_d;
      busy       <= (state == S_DC_CAL) || (state == S_GAIN_CAL);
      done       <= (state == S_RUN);
      fail       <= (state == S_FAIL);
      clk_filter <= ~clk_filter;
    end
  end

endmodule
